// File: rtl/norm_seq_ctrl.sv
// rtl/norm_seq_ctrl.sv - row-normalization sequencer for the SFP psum path
//
// Purpose: walks a block of psum-memory rows. For each row it reads the row,
// accumulates the local sum, pushes it to the peer core, waits for the peer
// sum, pops it, then runs the SFP divider. It flags a peer timeout and pulses
// done when the block completes.
//
// Ports:
//   clk, reset        single clock; synchronous active-low reset
//   start, num_rows   block request (sampled in IDLE), row count for the block
//   abort             synchronous cancel back to IDLE
//   ext_empty         peer-sum FIFO empty flag
//   pmem_rd/addr      psum-memory read strobe and row address
//   acc_en            local-sum accumulate enable
//   wr_sum            push local sum to the peer FIFO
//   fifo_ext_rd       pop one peer sum
//   div_en            normalize/divide enable
//   busy, done, err   status: not idle, completion pulse, sticky timeout
module norm_seq_ctrl #(
  parameter int unsigned ADDR_BW  = 4,
  parameter int unsigned NORM_LAT = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_BW:0]   num_rows,
  input  logic               abort,
  input  logic               ext_empty,
  output logic               pmem_rd,
  output logic [ADDR_BW-1:0] pmem_addr,
  output logic               acc_en,
  output logic               wr_sum,
  output logic               fifo_ext_rd,
  output logic               div_en,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_ACC, S_PUSH, S_WAIT, S_EXT, S_NORM, S_DONE
  } state_t;

  localparam logic [ADDR_BW:0] MAX_ROWS  = {1'b1, {ADDR_BW{1'b0}}};
  localparam logic [3:0]       NORM_LAST = 4'(NORM_LAT - 1);
  // One extra NORM cycle with div_en low, used only between rows, gives the
  // row-advance slot so the next RD shows the incremented address.
  localparam logic [3:0]       NORM_ADV  = 4'(NORM_LAT);
  localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [ADDR_BW:0]   row_q, row_d;
  logic [ADDR_BW:0]   n_reg_q, n_reg_d;
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic [3:0]         norm_cnt_q, norm_cnt_d;
  logic               err_q, err_d;

  logic               pmem_rd_q, pmem_rd_d;
  logic [ADDR_BW-1:0] pmem_addr_q, pmem_addr_d;
  logic               acc_en_q, acc_en_d;
  logic               wr_sum_q, wr_sum_d;
  logic               fifo_ext_rd_q, fifo_ext_rd_d;
  logic               div_en_q, div_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    n_reg_d    = n_reg_q;
    wait_cnt_d = wait_cnt_q;
    norm_cnt_d = norm_cnt_q;
    err_d      = err_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            n_reg_d = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
            row_d   = '0;
            err_d   = 1'b0;
            state_d = (num_rows == '0) ? S_DONE : S_RD;
          end
        end
        S_RD:   state_d = S_ACC;
        S_ACC:  state_d = S_PUSH;
        S_PUSH: begin
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
        S_WAIT: begin
          if (!ext_empty) begin
            state_d = S_EXT;
          end else if (wait_cnt_q == WAIT_LAST) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
        S_EXT: begin
          norm_cnt_d = '0;
          state_d    = S_NORM;
        end
        S_NORM: begin
          if (norm_cnt_q == NORM_ADV) begin
            row_d   = row_q + 1'b1;
            state_d = S_RD;
          end else if (norm_cnt_q == NORM_LAST && row_q == n_reg_q - 1'b1) begin
            state_d = S_DONE;
          end else begin
            norm_cnt_d = norm_cnt_q + 4'd1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so the registered copies
    // line up with the state register.
    pmem_rd_d     = (state_d == S_RD);
    pmem_addr_d   = (state_d == S_RD) ? row_d[ADDR_BW-1:0] : '0;
    acc_en_d      = (state_d == S_ACC);
    wr_sum_d      = (state_d == S_PUSH);
    fifo_ext_rd_d = (state_d == S_EXT);
    div_en_d      = (state_d == S_NORM) && (norm_cnt_d != NORM_ADV);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      n_reg_q       <= '0;
      wait_cnt_q    <= '0;
      norm_cnt_q    <= '0;
      err_q         <= 1'b0;
      pmem_rd_q     <= 1'b0;
      pmem_addr_q   <= '0;
      acc_en_q      <= 1'b0;
      wr_sum_q      <= 1'b0;
      fifo_ext_rd_q <= 1'b0;
      div_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      n_reg_q       <= n_reg_d;
      wait_cnt_q    <= wait_cnt_d;
      norm_cnt_q    <= norm_cnt_d;
      err_q         <= err_d;
      pmem_rd_q     <= pmem_rd_d;
      pmem_addr_q   <= pmem_addr_d;
      acc_en_q      <= acc_en_d;
      wr_sum_q      <= wr_sum_d;
      fifo_ext_rd_q <= fifo_ext_rd_d;
      div_en_q      <= div_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign pmem_rd     = pmem_rd_q;
  assign pmem_addr   = pmem_addr_q;
  assign acc_en      = acc_en_q;
  assign wr_sum      = wr_sum_q;
  assign fifo_ext_rd = fifo_ext_rd_q;
  assign div_en      = div_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_norm_seq_ctrl.sv
// tb/tb_norm_seq_ctrl.sv - self-checking bench for norm_seq_ctrl
module tb_norm_seq_ctrl;

  localparam int ADDR_BW  = 4;
  localparam int NORM_LAT = 2;
  localparam int TIMEOUT  = 255;

  logic               clk = 1'b0;
  logic               reset, start, abort, ext_empty;
  logic [ADDR_BW:0]   num_rows;
  logic               pmem_rd, acc_en, wr_sum, fifo_ext_rd, div_en, busy, done, err;
  logic [ADDR_BW-1:0] pmem_addr;

  norm_seq_ctrl #(.ADDR_BW(ADDR_BW), .NORM_LAT(NORM_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows), .abort(abort),
    .ext_empty(ext_empty), .pmem_rd(pmem_rd), .pmem_addr(pmem_addr), .acc_en(acc_en),
    .wr_sum(wr_sum), .fifo_ext_rd(fifo_ext_rd), .div_en(div_en), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: a block is a sequence of rows; each row is a timeline of offsets
  // t: 0 read, 1 accumulate, 2 push, then W wait cycles, one pop, NORM_LAT
  // divide cycles, and one advance slot before the next row.
  bit m_active, m_done, m_err;
  int m_row, m_n, m_t, m_w;

  // Monitor counters over DUT outputs, cleared per scenario.
  int cyc_no, n_rd, n_wr, n_ext, n_div, n_done, n_busy;
  int first_rd_addr, last_rd_cyc, rd_period, last_div_cyc, done_cyc, wr_cyc, ext_cyc, err_rise_cyc;
  logic [15:0] rd_mask;
  logic prev_err = 1'b0;

  task automatic model_step();
    if (!reset) begin
      m_active = 0; m_done = 0; m_err = 0; m_row = 0; m_n = 0; m_t = 0; m_w = 0;
    end else if (abort) begin
      m_active = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start) begin
        m_n = (int'(num_rows) > (1 << ADDR_BW)) ? (1 << ADDR_BW) : int'(num_rows);
        m_row = 0; m_err = 0; m_t = 0; m_w = 0;
        if (m_n == 0) m_done = 1;
        else m_active = 1;
      end
    end else if (m_t <= 2) begin
      m_t++;
    end else if (m_w == 0) begin
      if (!ext_empty) begin
        m_w = m_t - 2;
        m_t++;
      end else if (m_t - 2 == TIMEOUT) begin
        m_err = 1; m_active = 0;
      end else begin
        m_t++;
      end
    end else if (m_t == 3 + m_w + NORM_LAT) begin
      if (m_row == m_n - 1) begin
        m_active = 0; m_done = 1;
      end else begin
        m_t++;
      end
    end else if (m_t == 4 + m_w + NORM_LAT) begin
      m_row++; m_t = 0; m_w = 0;
    end else begin
      m_t++;
    end
  endtask

  function automatic logic [ADDR_BW+7:0] model_out();
    logic rd, ac, wr, ex, dv;
    logic [ADDR_BW-1:0] ad;
    rd = m_active && m_t == 0;
    ad = rd ? m_row[ADDR_BW-1:0] : '0;
    ac = m_active && m_t == 1;
    wr = m_active && m_t == 2;
    ex = m_active && m_w != 0 && m_t == 3 + m_w;
    dv = m_active && m_w != 0 && m_t >= 4 + m_w && m_t <= 3 + m_w + NORM_LAT;
    return {m_active | m_done, m_done, m_err, rd, ad, ac, wr, ex, dv};
  endfunction

  task automatic compare();
    logic [ADDR_BW+7:0] act, exp_v;
    exp_v = model_out();
    act = {busy, done, err, pmem_rd, pmem_addr, acc_en, wr_sum, fifo_ext_rd, div_en};
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL cycle_outputs at cycle %0d: got busy/done/err/rd/addr/acc/wr/ext/div=%b, expected %b",
               cyc_no, act, exp_v);
    end
    cyc_no++;
    if (pmem_rd === 1'b1) begin
      if (n_rd > 0) rd_period = cyc_no - last_rd_cyc;
      if (first_rd_addr < 0) first_rd_addr = int'(pmem_addr);
      last_rd_cyc = cyc_no;
      rd_mask = rd_mask | (16'd1 << pmem_addr);
      n_rd++;
    end
    if (wr_sum === 1'b1) begin n_wr++; wr_cyc = cyc_no; end
    if (fifo_ext_rd === 1'b1) begin n_ext++; ext_cyc = cyc_no; end
    if (div_en === 1'b1) begin n_div++; last_div_cyc = cyc_no; end
    if (done === 1'b1) begin n_done++; done_cyc = cyc_no; end
    if (busy === 1'b1) n_busy++;
    if (err === 1'b1 && prev_err !== 1'b1 && err_rise_cyc < 0) err_rise_cyc = cyc_no;
    prev_err = err;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
    end
  end

  task automatic clear_mon();
    n_rd = 0; n_wr = 0; n_ext = 0; n_div = 0; n_done = 0; n_busy = 0;
    first_rd_addr = -1; last_rd_cyc = 0; rd_period = 0; last_div_cyc = 0;
    done_cyc = 0; wr_cyc = 0; ext_cyc = 0; err_rise_cyc = -1; rd_mask = '0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp_v);
    n_vec++;
    if (got != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp_v);
    end
  endtask

  task automatic wait_done(input string name, input int bound);
    int k = 0;
    while (n_done == 0 && k < bound) begin step(); k++; end
    check(name, int'(n_done > 0), 1);
  endtask

  task automatic pulse_start(input int rows);
    num_rows = (ADDR_BW+1)'(rows);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int k;
    int hold;
    reset = 1'b0; start = 1'b0; abort = 1'b0; ext_empty = 1'b1; num_rows = '0;
    cyc_no = 0;
    clear_mon();
    repeat (3) step();
    check("reset_outputs", int'({busy, done, err, pmem_rd, pmem_addr, acc_en, wr_sum, fifo_ext_rd, div_en}), 0);
    reset = 1'b1;
    step();

    // Three rows, peer sum always available.
    clear_mon(); ext_empty = 1'b0;
    pulse_start(3);
    wait_done("rows3_done_seen", 200);
    check("rows3_rd_count", n_rd, 3);
    check("rows3_addr_mask", int'(rd_mask), 7);
    check("rows3_row_period", rd_period, 8);
    check("rows3_wr_count", n_wr, 3);
    check("rows3_ext_count", n_ext, 3);
    check("rows3_div_count", n_div, 6);
    check("rows3_done_after_div", done_cyc - last_div_cyc, 1);
    step();

    // One row, peer sum late by 10 cycles.
    clear_mon(); ext_empty = 1'b1;
    pulse_start(1);
    k = 0;
    while (n_wr == 0 && k < 20) begin step(); k++; end
    check("late_wr_seen", n_wr, 1);
    repeat (11) step();
    ext_empty = 1'b0;
    wait_done("late_done_seen", 50);
    check("late_wait_len", ext_cyc - wr_cyc - 1, 11);
    check("late_ext_count", n_ext, 1);
    check("late_err", int'(err), 0);
    step();

    // Two rows, peer never answers: timeout.
    clear_mon(); ext_empty = 1'b1;
    pulse_start(2);
    k = 0;
    while (err_rise_cyc < 0 && k < 400) begin step(); k++; end
    check("timeout_err_seen", int'(err_rise_cyc >= 0), 1);
    check("timeout_wait_cycles", err_rise_cyc - wr_cyc - 1, TIMEOUT);
    check("timeout_busy", int'(busy), 0);
    repeat (5) step();
    check("timeout_err_sticky", int'(err), 1);
    check("timeout_no_done", n_done, 0);
    check("timeout_wr_count", n_wr, 1);

    // Zero rows.
    clear_mon(); ext_empty = 1'b0;
    pulse_start(0);
    repeat (4) step();
    check("zero_busy_cycles", n_busy, 1);
    check("zero_done_count", n_done, 1);
    check("zero_strobes", n_rd + n_wr + n_ext, 0);
    check("zero_err_cleared", int'(err), 0);

    // Abort during NORM of row 1 of 4.
    clear_mon();
    pulse_start(4);
    k = 0;
    while (n_div < 3 && k < 100) begin step(); k++; end
    check("abort_reached_row1_norm", n_div, 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_div", int'(div_en), 0);
    repeat (3) step();
    check("abort_no_done", n_done, 0);
    clear_mon();
    pulse_start(1);
    wait_done("after_abort_done_seen", 50);
    check("after_abort_first_addr", first_rd_addr, 0);
    check("after_abort_rd_count", n_rd, 1);
    step();

    // Repeated starts while busy, then reset during WAIT.
    clear_mon(); ext_empty = 1'b1;
    pulse_start(2);
    for (int i = 0; i < 8; i++) begin
      start = (i % 2 == 0);
      num_rows = (ADDR_BW+1)'($urandom_range(0, 31));
      step();
    end
    check("busy_start_rd_count", n_rd, 1);
    check("busy_start_wr_count", n_wr, 1);
    reset = 1'b0; start = 1'b1;
    step();
    check("reset_mid_outputs", int'({busy, done, err, pmem_rd, pmem_addr, acc_en, wr_sum, fifo_ext_rd, div_en}), 0);
    reset = 1'b1; start = 1'b0;
    repeat (3) step();
    check("reset_mid_stays_idle", int'(busy), 0);

    // Randomized traffic; the per-cycle compare does the checking.
    hold = 0;
    for (int i = 0; i < 6000; i++) begin
      start    = ($urandom_range(0, 7) == 0);
      num_rows = (ADDR_BW+1)'($urandom_range(0, 31));
      abort    = ($urandom_range(0, 299) == 0);
      reset    = !($urandom_range(0, 799) == 0);
      if (hold > 0) begin
        ext_empty = 1'b1;
        hold--;
      end else begin
        ext_empty = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 999) == 0) hold = 300;
      end
      step();
    end
    start = 1'b0; abort = 1'b0; reset = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
